// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and keyboard receive path.
package ps2_pkg;

  // Host transmit sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } ps2_tx_state_e;

  // Keyboard command bytes.
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Defaults assume a 50 MHz system clock.
  localparam int unsigned INHIBIT_CYCLES_DEFAULT = 5000;     // 100 us
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;  // 20 ms
  localparam int unsigned SYNC_STAGES_DEFAULT    = 2;

  // Width of the shared inhibit/timeout counter.
  localparam int unsigned CntWidth = 20;

  // PS/2 frames use odd parity: data plus parity carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status and pin bundle between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;

  // Command source plus pad readback side.
  modport master (
    output tx_start, tx_data, ps2_clk_in, ps2_data_in,
    input  ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error
  );

  // Transmitter side.
  modport slave (
    input  tx_start, tx_data, ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error
  );

endinterface

// File: rtl/ps2_edge_sync.sv
// Synchronises the asynchronous PS/2 clock and data pins and flags falling clock edges.
// Shared with the keyboard receive path. SYNC_STAGES must be at least 2.
module ps2_edge_sync #(
  parameter int unsigned SYNC_STAGES = ps2_pkg::SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic globalReset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   clk_prev_q;

  // Synchroniser chains; reset to the idle bus level so leaving reset never looks like a fall.
  always_ff @(posedge clock) begin
    if (!globalReset_n) begin
      clk_q      <= '1;
      data_q     <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_q      <= {clk_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_q     <= {data_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q <= clk_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse when the synced clock goes from 1 to 0.
  always_comb begin
    clk_sync_o  = clk_q[SYNC_STAGES-1];
    data_sync_o = data_q[SYNC_STAGES-1];
    clk_fall_o  = clk_prev_q & ~clk_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one command
// byte out on device clock falls, then checks the device acknowledge. Both pins are driven
// as open-drain output enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
  input logic          clock,
  input logic          globalReset_n,
  ps2_host_tx_if.slave bus
);

  // Counter values at which the inhibit phase raises the start bit and then ends.
  localparam logic [CntWidth-1:0] InhibitPre  = CntWidth'(INHIBIT_CYCLES - 2);
  localparam logic [CntWidth-1:0] InhibitLast = CntWidth'(INHIBIT_CYCLES - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e       state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [7:0]          shift_q;
  logic                parity_q;
  logic [2:0]          bit_idx_q;
  logic                ack_q;
  logic                clk_oe_q;
  logic                data_oe_q;
  logic                busy_q;
  logic                done_q;
  logic                ack_ok_q;
  logic                error_q;

  logic                clk_s;
  logic                data_s;
  logic                fall;
  logic [CntWidth-1:0] cnt_inc;
  logic                timed;
  logic                timeout;

  ps2_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock         (clock),
    .globalReset_n (globalReset_n),
    .ps2_clk_i     (bus.ps2_clk_in),
    .ps2_data_i    (bus.ps2_data_in),
    .clk_sync_o    (clk_s),
    .data_sync_o   (data_s),
    .clk_fall_o    (fall)
  );

  // Saturating count and the timeout window, which covers everything from REQ onward.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntWidth'(1);
    timed   = (state_q != StIdle) && (state_q != StInhibit);
    timeout = (cnt_q >= TimeoutLast);
  end

  // Transfer sequencer with registered pin enables and status.
  always_ff @(posedge clock) begin
    if (!globalReset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= cnt_inc;
      // Timeout beats a coincident clock fall.
      if (timed && timeout) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        error_q   <= 1'b1;
        ack_ok_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (bus.tx_start) begin
              shift_q  <= bus.tx_data;
              parity_q <= odd_parity(bus.tx_data);
              clk_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              ack_ok_q <= 1'b0;
              state_q  <= StInhibit;
            end
          end
          StInhibit: begin
            // Start bit goes low during the final inhibit cycle, before the clock is released.
            if (cnt_q == InhibitPre) begin
              data_oe_q <= 1'b1;
            end
            if (cnt_q == InhibitLast) begin
              clk_oe_q  <= 1'b0;
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= StReq;
            end
          end
          StReq: begin
            if (fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= shift_q >> 1;
              state_q   <= StData;
            end
          end
          StData: begin
            // bit_idx_q is the index of the bit currently on the line.
            if (fall) begin
              if (bit_idx_q == 3'd7) begin
                data_oe_q <= ~parity_q;
                state_q   <= StParity;
              end else begin
                data_oe_q <= ~shift_q[0];
                shift_q   <= shift_q >> 1;
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
          StParity: begin
            if (fall) begin
              data_oe_q <= 1'b0;
              state_q   <= StStop;
            end
          end
          StStop: begin
            if (fall) begin
              ack_q   <= ~data_s;
              state_q <= StWaitIdle;
            end
          end
          StWaitIdle: begin
            if (clk_s && data_s) begin
              state_q  <= StIdle;
              cnt_q    <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              ack_ok_q <= ack_q;
              error_q  <= ~ack_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ack_ok      = ack_ok_q;
  assign bus.error       = error_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receive path and sends command bytes to the keyboard, for example LED set (0xED), reset (0xFF) and enable (0xF4). It drives the PS/2 clock and data lines as open-drain output enables, serialises one byte per request and checks the device acknowledge. It sits beside the keyboard receiver at the CPU top level and shares the same clock_ps2 and Keyboard_Data pins through tristate buffers.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles ps2_clk_oe is held (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, maximum cycles from clock release to acknowledge (20 ms)
SYNC_STAGES, 2, synchroniser depth on both PS/2 input lines

Ports:
clock  in  1  main 50 MHz clock
globalReset_n  in  1  reset, synchronous, active-low
tx_start  in  1  one-cycle request; sampled only in IDLE
tx_data  in  8  command byte; captured on the accepted tx_start
ps2_clk_in  in  1  PS/2 clock pin readback (asynchronous)
ps2_data_in  in  1  PS/2 data pin readback (asynchronous)
ps2_clk_oe  out  1  1 = drive clock pin low, 0 = release
ps2_data_oe  out  1  1 = drive data pin low, 0 = release
busy  out  1  high from the accepted start until the next IDLE
done  out  1  one-cycle pulse at the end of a transfer
ack_ok  out  1  valid with done: 1 = device acknowledged
error  out  1  one-cycle pulse on timeout or missing acknowledge

Behaviour:
- Reset: globalReset_n=0 at a clock rising edge puts the FSM in IDLE and clears all outputs to 0, so both lines are released. This also applies mid-transfer; the lines are released on that same edge.
- Input sync: ps2_clk_in and ps2_data_in each pass through SYNC_STAGES flops. fall = previous synced clock 1 and current synced clock 0; it is one clock wide.
- IDLE: on tx_start=1:
  - latch the shift register and compute parity = ~^tx_data (odd parity);
  - next cycle: ps2_clk_oe=1, busy=1, counter cleared.
  - tx_start outside IDLE is ignored, with no queueing.
- INHIBIT: hold ps2_clk_oe=1 for exactly INHIBIT_CYCLES. On the last cycle set ps2_data_oe=1 (start bit), then go to REQ.
- REQ: ps2_clk_oe=0 while ps2_data_oe stays 1. The timeout counter starts here. bit_idx=0. On fall go to DATA and drive bit0.
- Drive convention: the host changes data only on fall. ps2_data_oe = ~bit, so a 0 bit drives the line low and a 1 bit releases it.
- DATA: on each fall, shift out the next bit, LSB first. After bit7 has been presented, the next fall presents parity and moves to PARITY.
- PARITY: next fall sets ps2_data_oe=0 (stop bit = 1) and moves to STOP.
- STOP: next fall samples the synced data line into ack (data==0 means acknowledged) and moves to WAIT_IDLE.
- WAIT_IDLE:
  - when synced clock and data are both 1, go to IDLE, pulse done, and set ack_ok=ack;
  - if ack==0, error also pulses in that cycle;
  - ack_ok holds its value until the next accepted tx_start.
- Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, DATA, PARITY, STOP or WAIT_IDLE:
  - release both lines, pulse error and done, set ack_ok=0, return to IDLE.
  - If the timeout and a fall occur in the same cycle, the timeout wins.
- Counter: 20-bit saturating counter; cleared on every state entry except where noted (the timeout counter runs continuously from REQ).
- Simultaneous tx_start with reset: reset wins.
- Edge count per transfer: exactly 11 falls after REQ (8 data, parity, stop, ack).

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE;
  - command constants: CMD_SET_LED=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - default INHIBIT/TIMEOUT values.
- Sub-module ps2_edge_sync: synchroniser plus falling-edge detector. The keyboard receiver shares it.

Test Plan:
- tx_data=0xED with a behavioural device model clocking at about 12 kHz:
  - data line at successive falls reads 1,0,1,1,0,1,1,1, then parity 1, stop 1;
  - model acks low; done=1, ack_ok=1, error=0.
- tx_start once, then measure: ps2_clk_oe high for exactly 5000 cycles; ps2_data_oe rises on cycle 5000 before clock release.
- tx_data=0x00 gives parity bit 1; tx_data=0x01 gives parity bit 0. Both are checked at the 9th fall.
- Model never clocks: after 1000000 cycles from REQ, error=1, done=1, ack_ok=0, both oe=0, busy=0.
- Model leaves data high at the ack fall: done=1, ack_ok=0, error=1.
- Reset low during DATA bit 4: both oe=0 and busy=0 on that edge. A second tx_start pulsed mid-transfer produces no second INHIBIT.
